accum_bank_array: RTL and testbench
===================================

Name: accum_bank_array

Overview:
- Parametrised successor to the fixed single/double-buffered FC-layer accumulator.
- Accumulates CH parallel channels of unsigned partial sums into one of NUM_BANKS round-robin banks, with valid/ready handshakes on both the input stream and the drain side.
- Sits between the popcount/MAC stage and the output requantiser/writeback. Accumulation of the next vector overlaps draining of earlier ones.

Parameters:
- CH, 55, number of parallel output channels (neurons per fold).
- IN_W, 8, width of each per-channel input value (unsigned).
- ACC_W, 16, width of each per-channel accumulator; ACC_W >= IN_W.
- NUM_BANKS, 2, number of accumulator banks; minimum 1.
- BEAT_W, 8, width of the per-bank beat counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort: zero the bank currently being accumulated.
- in_valid  in  1  input beat valid.
- in_ready  out  1  the current write bank can accept a beat.
- in_last  in  1  final beat of the current vector.
- in_val  in  CH*IN_W  packed per-channel inputs; channel c is at [c*IN_W +: IN_W].
- out_valid  out  1  the oldest full bank is presented.
- out_ready  in  1  consumer accepts the presented bank.
- out_sum  out  CH*ACC_W  packed per-channel sums of the read bank.
- out_beats  out  BEAT_W  number of beats accumulated into the presented bank.
- out_ovf  out  CH  per-channel overflow flags of the presented bank.

Behaviour:
- Per-bank state is one of FREE, ACCUM or FULL.
- Pointers and counters:
  - wr_ptr and rd_ptr each wrap from NUM_BANKS-1 to 0.
  - full_cnt ranges 0..NUM_BANKS.
- Reset: all banks FREE with sums, beat counters and ovf flags at 0; wr_ptr=rd_ptr=0; full_cnt=0; in_ready=1; out_valid=0; out_sum=0; out_beats=0; out_ovf=0.
- in_ready is combinational: high when bank[wr_ptr] is not FULL.
- Input beat handshake (in_valid & in_ready):
  - For every channel c: sum[wr_ptr][c] <= sum[wr_ptr][c] + zero_ext(in_val[c]).
  - beats[wr_ptr] increments, saturating at all-ones.
  - State becomes ACCUM.
- Carry out of bit ACC_W-1 sets the sticky ovf[wr_ptr][c]. Without the feature the sum wraps modulo 2^ACC_W.
- Handshake with in_last=1:
  - The bank goes to FULL, wr_ptr advances and full_cnt increments.
  - A single-beat vector is legal.
- out_valid is registered and equals (full_cnt != 0). It asserts the cycle after the last-beat handshake: 1-cycle latency.
- out_sum, out_beats and out_ovf are read combinationally from bank[rd_ptr]. They are held stable while out_valid=1 and out_ready=0.
- Drain handshake (out_valid & out_ready):
  - bank[rd_ptr] is zeroed (sums, beats, ovf) and set FREE.
  - rd_ptr advances and full_cnt decrements.
- Backpressure: when all banks are FULL, in_ready=0. in_ready rises the cycle after a drain handshake frees the bank at wr_ptr.
- A last-beat handshake and a drain handshake in the same cycle:
  - They always touch different banks.
  - full_cnt is unchanged.
  - With NUM_BANKS=1 they cannot coincide, because in_ready=0 while the bank is FULL.
- clear:
  - Zeroes the ACCUM or FREE bank at wr_ptr; FULL banks are untouched.
  - clear has priority over a same-cycle input beat; that beat is discarded and in_ready is unaffected.
  - clear has no effect on the drain side.
- Asserting rst_n mid-operation discards all banks, including FULL ones.
- in_val is ignored when in_valid=0.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: per-channel saturating add. On carry-out the sum clamps to 2^ACC_W-1 and stays there until drained; ovf is set as before.
- Undefined: modulo-2^ACC_W wrap. ovf still records that a wrap occurred.

Decomposition:
- Shared package accum_pkg holds:
  - bank state enum (FREE/ACCUM/FULL);
  - typedefs for packed channel vectors, parameterised via localparams mirroring CH, IN_W and ACC_W;
  - a function ptr_next(ptr, NUM_BANKS).
- One natural sub-module: accum_lane. It is a single-channel adder with ovf/saturation, instantiated CH times in a generate loop. The top level owns the bank registers, pointers and handshakes.

Test Plan:
- CH=4, NUM_BANKS=2. Beats {1,2,3,4}x3 with last on the third beat, out_ready=1 -> one cycle later out_valid=1, out_sum={3,6,9,12}, out_beats=3, out_ovf=0.
- NUM_BANKS=2, out_ready=0. Send three single-beat vectors -> in_ready drops after the second; raise out_ready -> first bank drained, in_ready=1 the next cycle, third vector accepted, drain order preserved.
- ACC_W=8, IN_W=8. Beats 200 then 100 (last):
  - without ACC_SAT_EN -> out_sum=44, out_ovf=1;
  - with ACC_SAT_EN -> out_sum=255, out_ovf=1.
- Mid-vector clear after beats 5 and 7, then beat 1 with last -> out_sum=1, out_beats=1. A FULL bank already waiting is unchanged.
- NUM_BANKS=3 continuous streaming with out_ready toggling randomly -> no beat lost or duplicated, pointers wrap 2->0, scoreboard matches.
- Reset asserted while one bank is FULL and one is ACCUM -> out_valid=0, in_ready=1, out_sum=0 immediately.

Source files
------------

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared bank state, channel vector types and pointer helper for the accumulator bank array
package accum_pkg;

    localparam int PKG_CH        = 55;
    localparam int PKG_IN_W      = 8;
    localparam int PKG_ACC_W     = 16;
    localparam int PKG_NUM_BANKS = 2;
    localparam int PKG_BEAT_W    = 8;

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_ACCUM = 2'd1,
        BANK_FULL  = 2'd2
    } bank_state_t;

    typedef logic [PKG_CH*PKG_IN_W-1:0]  ch_in_vec_t;
    typedef logic [PKG_CH*PKG_ACC_W-1:0] ch_sum_vec_t;
    typedef logic [PKG_CH-1:0]           ch_flag_vec_t;

    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned num_banks);
        return (ptr >= num_banks - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/accum_lane.sv
// rtl/accum_lane.sv - single-channel accumulate step with carry detect; ACC_SAT_EN selects clamping instead of wrap
module accum_lane
    import accum_pkg::*;
#(
    parameter int IN_W  = PKG_IN_W,
    parameter int ACC_W = PKG_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  val,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, val};
    assign carry = wide[ACC_W];

`ifdef ACC_SAT_EN
    // A clamped lane stays at all-ones: further adds carry out again and re-clamp.
    assign sum = carry ? '1 : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/accum_bank_array.sv
// rtl/accum_bank_array.sv - round-robin multi-bank channel accumulator with stream input and drain handshakes
module accum_bank_array
    import accum_pkg::*;
#(
    parameter int CH        = PKG_CH,
    parameter int IN_W      = PKG_IN_W,
    parameter int ACC_W     = PKG_ACC_W,
    parameter int NUM_BANKS = PKG_NUM_BANKS,
    parameter int BEAT_W    = PKG_BEAT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [CH*IN_W-1:0]  in_val,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*ACC_W-1:0] out_sum,
    output logic [BEAT_W-1:0]   out_beats,
    output logic [CH-1:0]       out_ovf
);

    localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(NUM_BANKS + 1);

    bank_state_t       state [NUM_BANKS];
    logic [ACC_W-1:0]  sums  [NUM_BANKS][CH];
    logic [BEAT_W-1:0] beats [NUM_BANKS];
    logic [CH-1:0]     ovf   [NUM_BANKS];

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  full_cnt, full_cnt_next;
    logic [ACC_W-1:0]  lane_sum [CH];
    logic [CH-1:0]     lane_carry;
    logic              acc_fire, last_fire, drain_fire;

    assign in_ready   = (state[wr_ptr] != BANK_FULL);
    // clear wins over a same-cycle beat, so the beat is simply not taken
    assign acc_fire   = in_valid & in_ready & ~clear;
    assign last_fire  = acc_fire & in_last;
    assign drain_fire = out_valid & out_ready;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        accum_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
            .acc   (sums[wr_ptr][c]),
            .val   (in_val[c*IN_W +: IN_W]),
            .sum   (lane_sum[c]),
            .carry (lane_carry[c])
        );
        assign out_sum[c*ACC_W +: ACC_W] = sums[rd_ptr][c];
    end

    assign out_beats = beats[rd_ptr];
    assign out_ovf   = ovf[rd_ptr];

    always_comb begin
        full_cnt_next = full_cnt;
        if (last_fire && !drain_fire) begin
            full_cnt_next = full_cnt + CNT_W'(1);
        end else if (!last_fire && drain_fire) begin
            full_cnt_next = full_cnt - CNT_W'(1);
        end
    end

    // Filling and draining never hit the same bank: one needs it non-FULL, the other FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            full_cnt  <= '0;
            out_valid <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= BANK_FREE;
                beats[b] <= '0;
                ovf[b]   <= '0;
                for (int c = 0; c < CH; c++) begin
                    sums[b][c] <= '0;
                end
            end
        end else begin
            full_cnt  <= full_cnt_next;
            out_valid <= (full_cnt_next != '0);
            if (drain_fire) begin
                state[rd_ptr] <= BANK_FREE;
                beats[rd_ptr] <= '0;
                ovf[rd_ptr]   <= '0;
                for (int c = 0; c < CH; c++) begin
                    sums[rd_ptr][c] <= '0;
                end
                rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), NUM_BANKS));
            end
            if (clear) begin
                if (state[wr_ptr] != BANK_FULL) begin
                    state[wr_ptr] <= BANK_FREE;
                    beats[wr_ptr] <= '0;
                    ovf[wr_ptr]   <= '0;
                    for (int c = 0; c < CH; c++) begin
                        sums[wr_ptr][c] <= '0;
                    end
                end
            end else if (acc_fire) begin
                for (int c = 0; c < CH; c++) begin
                    sums[wr_ptr][c] <= lane_sum[c];
                end
                ovf[wr_ptr]   <= ovf[wr_ptr] | lane_carry;
                beats[wr_ptr] <= (beats[wr_ptr] == '1) ? beats[wr_ptr] : beats[wr_ptr] + BEAT_W'(1);
                state[wr_ptr] <= in_last ? BANK_FULL : BANK_ACCUM;
                if (in_last) begin
                    wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), NUM_BANKS));
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_bank_array.sv
// tb/tb_accum_bank_array.sv - scoreboard bench for accum_bank_array (2-bank and 3-bank instances, ACC_SAT_EN aware)
module tb_accum_bank_array;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  beats;
        logic [3:0]  ovf;
    } exp_t;

    logic clk, rst_n;

    logic        a_clear, a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
    logic [31:0] a_in_val, a_out_sum;
    logic [7:0]  a_out_beats;
    logic [3:0]  a_out_ovf;

    logic        b_clear, b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
    logic [31:0] b_in_val, b_out_sum;
    logic [7:0]  b_out_beats;
    logic [3:0]  b_out_ovf;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stream_on = 0;

    accum_bank_array #(.CH(4), .IN_W(8), .ACC_W(8), .NUM_BANKS(2), .BEAT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_last(a_in_last), .in_val(a_in_val),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .out_beats(a_out_beats), .out_ovf(a_out_ovf)
    );

    accum_bank_array #(.CH(4), .IN_W(8), .ACC_W(8), .NUM_BANKS(3), .BEAT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_last(b_in_last), .in_val(b_in_val),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .out_beats(b_out_beats), .out_ovf(b_out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic void check_drain(input string name, input exp_t got, input exp_t e);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s got sum=%h beats=%0d ovf=%b exp sum=%h beats=%0d ovf=%b",
                     name, got.sum, got.beats, got.ovf, e.sum, e.beats, e.ovf);
        end
    endfunction

    // Scoreboard monitor: every drain handshake pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL drain_a unexpected sum=%h", a_out_sum);
                end else begin
                    check_drain("drain_a", {a_out_sum, a_out_beats, a_out_ovf}, q_a.pop_front());
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL drain_b unexpected sum=%h", b_out_sum);
                end else begin
                    check_drain("drain_b", {b_out_sum, b_out_beats, b_out_ovf}, q_b.pop_front());
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        while (1) begin
            @(posedge clk); #1;
            if (stream_on) b_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input bit sel, input logic [31:0] v, input logic last);
        int n = 0;
        if (sel) begin b_in_valid = 1; b_in_val = v; b_in_last = last; end
        else     begin a_in_valid = 1; a_in_val = v; a_in_last = last; end
        while (!(sel ? b_in_ready : a_in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_timeout sel=%0d got=in_ready_low exp=in_ready_high", sel);
        end else begin
            @(posedge clk); #1;
        end
        if (sel) begin b_in_valid = 0; b_in_last = 0; end
        else     begin a_in_valid = 0; a_in_last = 0; end
    endtask

    task automatic drain_wait();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic stream_vec(input int k, input int len);
        exp_t        e;
        logic [31:0] v;
        e = '0;
        for (int j = 0; j < len; j++) begin
            for (int c = 0; c < 4; c++) begin
                v[c*8 +: 8]     = 8'((k * 3 + j * 5 + c * 7) % 32);
                e.sum[c*8 +: 8] = e.sum[c*8 +: 8] + v[c*8 +: 8];
            end
            e.beats = e.beats + 8'd1;
            if (j == len - 1) q_b.push_back(e);
            send(1'b1, v, j == len - 1);
        end
    endtask

    initial begin
        rst_n = 0;
        a_clear = 0; a_in_valid = 0; a_in_last = 0; a_in_val = 32'hDEADBEEF; a_out_ready = 0;
        b_clear = 0; b_in_valid = 0; b_in_last = 0; b_in_val = 32'hDEADBEEF; b_out_ready = 0;
        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_sum", a_out_sum, 0);
        check("rst_out_beats", a_out_beats, 0);
        check("rst_out_ovf", a_out_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // three beats of {4,3,2,1} (channel 0 lowest)
        a_out_ready = 1;
        q_a.push_back('{sum: 32'h0C090603, beats: 8'd3, ovf: 4'b0000});
        send(1'b0, 32'h04030201, 1'b0);
        check("t1_no_valid_early", a_out_valid, 0);
        send(1'b0, 32'h04030201, 1'b0);
        send(1'b0, 32'h04030201, 1'b1);
        check("t1_valid_latency", a_out_valid, 1);
        drain_wait();

        // backpressure with both banks full
        a_out_ready = 0;
        q_a.push_back('{sum: 32'h01010101, beats: 8'd1, ovf: 4'b0000});
        send(1'b0, 32'h01010101, 1'b1);
        q_a.push_back('{sum: 32'h02020202, beats: 8'd1, ovf: 4'b0000});
        send(1'b0, 32'h02020202, 1'b1);
        check("bp_in_ready_low", a_in_ready, 0);
        a_out_ready = 1;
        @(posedge clk); #1;
        check("bp_in_ready_rise", a_in_ready, 1);
        q_a.push_back('{sum: 32'h03030303, beats: 8'd1, ovf: 4'b0000});
        send(1'b0, 32'h03030303, 1'b1);
        drain_wait();

        // overflow: ch0 200+100, ch1 10+20, ch2 255+1, ch3 0+0
`ifdef ACC_SAT_EN
        q_a.push_back('{sum: 32'h00FF1EFF, beats: 8'd2, ovf: 4'b0101});
`else
        q_a.push_back('{sum: 32'h00001E2C, beats: 8'd2, ovf: 4'b0101});
`endif
        send(1'b0, 32'h00FF0AC8, 1'b0);
        send(1'b0, 32'h00011464, 1'b1);
        drain_wait();

        // mid-vector clear with a FULL bank waiting
        a_out_ready = 0;
        q_a.push_back('{sum: 32'h09090909, beats: 8'd1, ovf: 4'b0000});
        send(1'b0, 32'h09090909, 1'b1);
        send(1'b0, 32'h05050505, 1'b0);
        send(1'b0, 32'h07070707, 1'b0);
        a_clear = 1; a_in_valid = 1; a_in_last = 1; a_in_val = 32'h30303030;
        @(posedge clk); #1;
        a_clear = 0; a_in_valid = 0; a_in_last = 0;
        check("clr_in_ready", a_in_ready, 1);
        check("clr_full_valid", a_out_valid, 1);
        check("clr_full_sum", a_out_sum, 32'h09090909);
        check("clr_full_beats", a_out_beats, 1);
        q_a.push_back('{sum: 32'h01010101, beats: 8'd1, ovf: 4'b0000});
        send(1'b0, 32'h01010101, 1'b1);
        a_out_ready = 1;
        drain_wait();

        // reset with one FULL and one ACCUM bank
        a_out_ready = 0;
        send(1'b0, 32'h11111111, 1'b1);
        send(1'b0, 32'h22222222, 1'b0);
        rst_n = 0;
        #1;
        check("mrst_out_valid", a_out_valid, 0);
        check("mrst_in_ready", a_in_ready, 1);
        check("mrst_out_sum", a_out_sum, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // three-bank streaming with random drain backpressure
        stream_on = 1;
        for (int k = 0; k < 8; k++) stream_vec(k, (k % 3) + 1);
        stream_on = 0;
        @(posedge clk); #2;
        b_out_ready = 1;
        drain_wait();

        check("q_a_empty", 64'(q_a.size()), 0);
        check("q_b_empty", 64'(q_b.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
